// File: rtl/spu_fetch_if.sv
// Signal bundle of the SPU fetch stage: instruction-memory port, decode handshake,
// branch redirect and status/performance outputs.
interface spu_fetch_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [63:0]     imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_ins0;
  logic [31:0]     dec_ins1;
  logic [PC_W-1:0] dec_pc;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halted;
  logic [31:0]     perf_pairs;
  logic [31:0]     perf_stall;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output dec_valid,
    input  dec_ready,
    output dec_ins0, dec_ins1, dec_pc,
    input  redirect, redirect_pc,
    output halted, perf_pairs, perf_stall
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  dec_valid,
    output dec_ready,
    input  dec_ins0, dec_ins1, dec_pc,
    output redirect, redirect_pc,
    input  halted, perf_pairs, perf_stall
  );
endinterface

// File: rtl/spu_fetch.sv
// SPU dual-issue fetch stage: PC, credit-based pair requests, pair FIFO, redirect and STOP halt.
// Define SPU_FETCH_PERF_EN to build the saturating perf_pairs/perf_stall counters.
module spu_fetch #(
  parameter int PC_W       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  spu_fetch_if.master bus
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [31:0]     NOP     = 32'h4020_0000;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0]     ins0;
    logic [31:0]     ins1;
    logic [PC_W-1:0] pc;
  } entry_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             req_q, req_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic             req_nop_q, req_nop_d;
  logic             resp_v_q, resp_v_d;
  logic [PC_W-1:0]  resp_pc_q;
  logic             resp_nop_q;
  logic             kill;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_nx;
  logic [CNT_W:0]   need;
  entry_t           push_entry, head;
  logic             push, pop, stop_seen;

  always_comb begin
    push_entry.ins0 = resp_nop_q ? NOP : bus.imem_rdata[63:32];
    push_entry.ins1 = bus.imem_rdata[31:0];
    push_entry.pc   = resp_pc_q;
  end

  assign stop_seen = resp_v_q && (push_entry.ins0[31:21] == 11'd0 ||
                                  push_entry.ins1[31:21] == 11'd0);
  assign pop       = bus.dec_valid & bus.dec_ready;
  assign push      = resp_v_q & ~bus.redirect;
  assign count_nx  = count_q + CNT_W'(push) - CNT_W'(pop);
  // Credit: entries after this edge, plus the response still outstanding, plus the new one.
  assign need      = {1'b0, count_nx} + (CNT_W+1)'(req_q) + (CNT_W+1)'(1);

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = 1'b0;
    addr_d    = addr_q;
    req_nop_d = 1'b0;
    kill      = 1'b0;
    if (bus.redirect) begin
      state_d   = RUN;
      kill      = 1'b1;
      req_d     = 1'b1;
      addr_d    = {bus.redirect_pc[PC_W-1:3], 3'b000};
      req_nop_d = bus.redirect_pc[2];
      pc_d      = addr_d + PC_W'(8);
    end else begin
      case (state_q)
        RUN: begin
          if (stop_seen) begin
            state_d = HALT;
            kill    = 1'b1;
          end else if (need <= DEPTH_C) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            pc_d   = pc_q + PC_W'(8);
          end
        end
        HALT: ;
      endcase
    end
  end

  assign resp_v_d = req_q & ~kill;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      req_nop_q  <= 1'b0;
      resp_v_q   <= 1'b0;
      resp_pc_q  <= '0;
      resp_nop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      req_nop_q  <= req_nop_d;
      resp_v_q   <= resp_v_d;
      resp_pc_q  <= addr_q;
      resp_nop_q <= req_nop_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_nx;
    end
  end

  // NOTE: the storage array has no reset; only pointers and count are reset, and the
  // head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign head          = fifo_mem[rd_ptr_q];
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_ins0  = bus.dec_valid ? head.ins0 : '0;
  assign bus.dec_ins1  = bus.dec_valid ? head.ins1 : '0;
  assign bus.dec_pc    = bus.dec_valid ? head.pc   : '0;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.halted    = (state_q == HALT);

`ifdef SPU_FETCH_PERF_EN
  logic [31:0] pairs_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pairs_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && pairs_q != '1) pairs_q <= pairs_q + 32'd1;
      if (bus.dec_valid && !bus.dec_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.perf_pairs = pairs_q;
  assign bus.perf_stall = stall_q;
`else
  assign bus.perf_pairs = '0;
  assign bus.perf_stall = '0;
`endif

endmodule

// File: tb/tb_spu_fetch.sv
// Scoreboard bench for spu_fetch: a stimulus thread queues expected pairs, a monitor
// pops and compares on every decode handshake.
module tb_spu_fetch;
  localparam int          PC_W    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] NOP     = 32'h4020_0000;
  localparam logic [31:0] NO_STOP = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] ins0;
    logic [31:0] ins1;
    logic [31:0] pc;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spu_fetch_if #(.PC_W(PC_W)) bus();
  spu_fetch #(.PC_W(PC_W), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks   = 0;
  int          failures = 0;
  int          req_cnt  = 0;
  int          hs_cnt   = 0;
  pair_t       exp_q[$];
  logic [31:0] stop_addr = NO_STOP;
  logic [31:0] mem_a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory image: pair at byte address a holds {a/4, a/4+1} tagged with bit 31 so it is never STOP.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] i0, i1;
    i0 = 32'h8000_0000 | (a >> 2);
    i1 = i0 | 32'd1;
    if (a == stop_addr) i1 = 32'h0;
    return {i0, i1};
  endfunction

  function automatic pair_t exp_pair(input logic [31:0] a, input bit nop0);
    logic [63:0] w;
    pair_t p;
    w = mem_word(a);
    p.ins0 = nop0 ? NOP : w[63:32];
    p.ins1 = w[31:0];
    p.pc   = a;
    return p;
  endfunction

  task automatic push_run(input logic [31:0] start, input int n, input bit nop_first);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_pair(start + 32'(8 * i), nop_first && i == 0));
  endtask

  task automatic wait_pc(input string name, input logic [31:0] pc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.dec_valid && bus.dec_pc == pc) && n < 100);
    check(name, {bus.dec_valid, bus.dec_pc}, {1'b1, pc});
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(posedge clk); #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(posedge clk); #1;
    bus.redirect    = 1'b0;
    exp_q.delete();
  endtask

  // Synchronous instruction memory: data for a request appears the following cycle.
  initial begin
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.imem_req) begin
        mem_a = bus.imem_addr;
        #1 bus.imem_rdata = mem_word(mem_a);
      end else begin
        #1 bus.imem_rdata = 64'hFFFF_0000_FFFF_0000;
      end
    end
  end

  initial begin : monitor
    pair_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.imem_req) req_cnt++;
        if (bus.dec_valid && bus.dec_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pair: got pc %0h expected none", bus.dec_pc);
          end else begin
            e = exp_q.pop_front();
            check("dec_pair", {32'h0, bus.dec_ins0, bus.dec_ins1, bus.dec_pc}, {32'h0, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int gaps, n, r0;
    rst             = 1'b1;
    bus.dec_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req",   bus.imem_req,   0);
    check("rst_imem_addr",  bus.imem_addr,  0);
    check("rst_dec_valid",  bus.dec_valid,  0);
    check("rst_dec_ins",    {bus.dec_ins0, bus.dec_ins1}, 0);
    check("rst_dec_pc",     bus.dec_pc,     0);
    check("rst_halted",     bus.halted,     0);
    check("rst_perf",       {bus.perf_pairs, bus.perf_stall}, 0);

    // Streaming with decode always ready.
    push_run(32'h0, 64, 1'b0);
    bus.dec_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("first_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
    @(negedge clk);
    check("latency_not_yet", bus.dec_valid, 0);
    @(negedge clk);
    check("first_valid", {bus.dec_valid, bus.dec_pc}, {1'b1, 32'h0});
    gaps = 0;
    repeat (11) begin
      @(negedge clk);
      if (!bus.dec_valid) gaps++;
    end
    check("no_gaps", gaps, 0);

    // Back-pressure fills the buffer and stops requests.
    @(posedge clk); #1 bus.dec_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("bp_req_drop", bus.imem_req, 0);
    check("bp_valid",    bus.dec_valid, 1);
    check("bp_buffered", req_cnt - hs_cnt, DEPTH);
    bus.dec_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Odd-aligned redirect while full.
    #1 bus.dec_ready = 1'b0;
    repeat (8) @(posedge clk);
    pulse_redirect(32'h104);
    push_run(32'h100, 20, 1'b1);
    check("redir_flush", bus.dec_valid, 0);
    check("redir_req",   {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});
    bus.dec_ready = 1'b1;
    wait_pc("redir_target", 32'h100);
    check("redir_nop", bus.dec_ins0, NOP);
    repeat (6) @(posedge clk);

    // STOP in the pair at 0x18.
    stop_addr = 32'h18;
    pulse_redirect(32'h0);
    push_run(32'h0, 4, 1'b0);
    wait_pc("stop_pair", 32'h18);
    check("stop_halted", bus.halted, 1);
    check("stop_no_req", bus.imem_req, 0);
    @(posedge clk); #1;
    r0 = req_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("halt_no_req", req_cnt - r0, 0);
    check("halt_hold", bus.halted, 1);

    // Resume from HALT, then redirect coincident with the STOP arrival at 0x60.
    stop_addr = 32'h60;
    pulse_redirect(32'h40);
    push_run(32'h40, 4, 1'b0);
    check("resume_halted", bus.halted, 0);
    check("resume_req", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h40});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.imem_req && bus.imem_addr == 32'h60) && n < 50);
    check("stop_req_seen", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h60});
    pulse_redirect(32'h200);
    stop_addr = NO_STOP;
    push_run(32'h200, 16, 1'b0);
    check("race_halted", bus.halted, 0);
    wait_pc("race_target", 32'h200);
    check("race_run", bus.halted, 0);
    repeat (6) @(posedge clk);

    // Reset mid-operation, then performance counters.
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {bus.imem_req, bus.dec_valid, bus.halted}, 0);
    check("midrst_perf", {bus.perf_pairs, bus.perf_stall}, 0);
    exp_q.delete();
    push_run(32'h0, 16, 1'b0);
    bus.dec_ready = 1'b0;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dec_valid && n < 20);
    check("perf_first_valid", bus.dec_valid, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 bus.dec_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.dec_ready = 1'b0;
    @(negedge clk);
`ifdef SPU_FETCH_PERF_EN
    check("perf_stall", bus.perf_stall, 5);
    check("perf_pairs", bus.perf_pairs, 8);
`else
    check("perf_stall", bus.perf_stall, 0);
    check("perf_pairs", bus.perf_pairs, 0);
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
